cg_iteration_sequencer: RTL and testbench

//   FSM sequencer for one conjugate-gradient solve. Replaces ad-hoc start/finish glue between the CG datapath units.

---
 rtl/cg_iteration_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_cg_iteration_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cg_iteration_sequencer.sv
// Conjugate-gradient iteration sequencer: orders RR0, AP, ALPHA, XR, RR, CHECK, BETA, P.
// Latency: a stage starts 1 cycle after the previous op_done; CHECK is 1 cycle; done 1 cycle after the decision.
// Backpressure: beat_rd is issued only while beat_rdy=1; abort stops all strobes on the next cycle.
module cg_iteration_sequencer #(
  parameter int W      = 32,
  parameter int LANES  = 8,
  parameter int ITER_W = 16,
  parameter int LEN_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              abort,
  input  logic [LEN_W-1:0]  total,
  input  logic [W-1:0]      tolerance,
  input  logic [ITER_W-1:0] max_iter,
  output logic              op_start,
  output logic [2:0]        op_sel,
  input  logic              op_done,
  input  logic [W-1:0]      op_result,
  output logic              beat_rd,
  output logic [LEN_W-1:0]  beat_idx,
  input  logic              beat_rdy,
  output logic [W-1:0]      rs_old,
  output logic [W-1:0]      rs_new,
  output logic [ITER_W-1:0] iter,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status
);

  typedef enum logic [3:0] {
    S_IDLE, S_RR0, S_AP, S_ALPHA, S_XR, S_RR, S_CHECK, S_BETA, S_P, S_ZLEN, S_DONE
  } state_t;

  localparam logic [LEN_W-1:0] LANES_L = LEN_W'(LANES);

  state_t              state_q, state_d;
  logic                first_q, first_d;     // first cycle of a stage: op_start
  logic [LEN_W-1:0]    issued_q, issued_d;   // beats issued in the current stage
  logic [LEN_W-1:0]    nb_q, nb_d;           // beats per vector
  logic [W-2:0]        tol_q, tol_d;         // magnitude bits only; sign is ignored
  logic [ITER_W-1:0]   max_q, max_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [W-1:0]        rs_old_q, rs_old_d;
  logic [W-1:0]        rs_new_q, rs_new_d;
  logic [1:0]          status_q, status_d;
  logic                limit_q, limit_d;     // limit reached: finish this iteration, then stop

  logic                streaming, stage_act;
  logic [LEN_W-1:0]    nb_go;
  logic [ITER_W:0]     iter_plus;
  logic                limit_hit;
  logic                unused_tol_sign;

  assign nb_go           = total / LANES_L + {{(LEN_W-1){1'b0}}, ((total % LANES_L) != '0)};
  assign iter_plus       = {1'b0, iter_q} + (ITER_W+1)'(1);
  assign limit_hit       = (max_q != '0) && (iter_plus == {1'b0, max_q});
  assign unused_tol_sign = tolerance[W-1];

  assign rs_old = rs_old_q;
  assign rs_new = rs_new_q;
  assign iter   = iter_q;
  assign status = status_q;

  // Next-state, per-stage strobes and scalar latching.
  always_comb begin
    state_d  = state_q;
    first_d  = 1'b0;
    issued_d = issued_q;
    nb_d     = nb_q;
    tol_d    = tol_q;
    max_d    = max_q;
    iter_d   = iter_q;
    rs_old_d = rs_old_q;
    rs_new_d = rs_new_q;
    status_d = status_q;
    limit_d  = limit_q;
    op_sel   = 3'd0;

    streaming = (state_q == S_RR0) || (state_q == S_AP) || (state_q == S_XR) ||
                (state_q == S_RR)  || (state_q == S_P);
    stage_act = streaming || (state_q == S_ALPHA) || (state_q == S_BETA);
    op_start  = stage_act && first_q;
    beat_rd   = streaming && !first_q && beat_rdy && (issued_q < nb_q);
    beat_idx  = streaming ? issued_q : '0;
    busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    done      = (state_q == S_DONE);

    case (state_q)
      S_RR0:   op_sel = 3'd0;
      S_AP:    op_sel = 3'd1;
      S_ALPHA: op_sel = 3'd2;
      S_XR:    op_sel = 3'd3;
      S_RR:    op_sel = 3'd4;
      S_CHECK: op_sel = 3'd4;
      S_BETA:  op_sel = 3'd5;
      S_P:     op_sel = 3'd6;
      default: op_sel = 3'd0;
    endcase

    if (beat_rd) issued_d = issued_q + LEN_W'(1);

    if (busy && abort) begin
      // abort outranks any op_done arriving in the same cycle
      state_d  = S_DONE;
      status_d = 2'd2;
    end else begin
      case (state_q)
        S_IDLE: if (go) begin
          tol_d    = tolerance[W-2:0];
          max_d    = max_iter;
          nb_d     = nb_go;
          rs_old_d = '0;
          rs_new_d = '0;
          iter_d   = '0;
          limit_d  = 1'b0;
          status_d = 2'd0;
          state_d  = (total == '0) ? S_ZLEN : S_RR0;
        end
        S_ZLEN: begin
          state_d  = S_DONE;
          status_d = 2'd3;
        end
        S_RR0: if (op_done) begin
          rs_old_d = op_result;
          if (op_result[W-2:0] <= tol_q) begin
            state_d  = S_DONE;
            status_d = 2'd0;
          end else begin
            state_d = S_AP;
          end
        end
        S_AP:    if (op_done) state_d = S_ALPHA;
        S_ALPHA: if (op_done) state_d = S_XR;
        S_XR:    if (op_done) state_d = S_RR;
        S_RR: if (op_done) begin
          rs_new_d = op_result;
          state_d  = S_CHECK;
        end
        S_CHECK: begin
          if (rs_new_q[W-2:0] <= tol_q) begin
            state_d  = S_DONE;
            status_d = 2'd0;
          end else begin
            // the last allowed iteration still runs BETA/P so iter counts it as completed
            if (limit_hit) limit_d = 1'b1;
            state_d = S_BETA;
          end
        end
        S_BETA: if (op_done) state_d = S_P;
        S_P: if (op_done) begin
          rs_old_d = rs_new_q;
          if (iter_q != {ITER_W{1'b1}}) iter_d = iter_q + ITER_W'(1);
          if (limit_q) begin
            state_d  = S_DONE;
            status_d = 2'd1;
          end else begin
            state_d = S_AP;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // any state change arms op_start and restarts the beat count for the new stage
    if (state_d != state_q) begin
      first_d  = 1'b1;
      issued_d = '0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      first_q  <= 1'b0;
      issued_q <= '0;
      nb_q     <= '0;
      tol_q    <= '0;
      max_q    <= '0;
      iter_q   <= '0;
      rs_old_q <= '0;
      rs_new_q <= '0;
      status_q <= 2'd0;
      limit_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      first_q  <= first_d;
      issued_q <= issued_d;
      nb_q     <= nb_d;
      tol_q    <= tol_d;
      max_q    <= max_d;
      iter_q   <= iter_d;
      rs_old_q <= rs_old_d;
      rs_new_q <= rs_new_d;
      status_q <= status_d;
      limit_q  <= limit_d;
    end
  end

endmodule

// File: tb/tb_cg_iteration_sequencer.sv
// Bench for cg_iteration_sequencer: directed solves with a unit responder.
// Expected op_start/beat/done events are queued by the stimulus and popped by a negedge monitor.
// Covers reset, beat counts, backpressure, convergence, iteration limit, zero length, abort, mid-solve reset.
module tb_cg_iteration_sequencer;

  logic        clk = 1'b0;
  logic        reset, go, abort, op_done, beat_rdy;
  logic [31:0] tot, tol, op_result;
  logic [15:0] max_iter;
  logic        op_start, beat_rd, busy, done;
  logic [2:0]  op_sel;
  logic [31:0] beat_idx, rs_old, rs_new;
  logic [15:0] iter;
  logic [1:0]  status;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    int          kind;   // 0 op_start, 1 beat, 2 done
    int          a;      // op_sel or status
    int          b;      // beat_idx or iter
    logic [31:0] c;      // rs_old at done
  } ev_t;
  ev_t expq[$];

  localparam logic [31:0] TOL = 32'h283424DC;

  cg_iteration_sequencer dut (
    .clk(clk), .reset(reset), .go(go), .abort(abort),
    .total(tot), .tolerance(tol), .max_iter(max_iter),
    .op_start(op_start), .op_sel(op_sel), .op_done(op_done), .op_result(op_result),
    .beat_rd(beat_rd), .beat_idx(beat_idx), .beat_rdy(beat_rdy),
    .rs_old(rs_old), .rs_new(rs_new), .iter(iter),
    .busy(busy), .done(done), .status(status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic push(input int kind, input int a, input int b, input logic [31:0] c);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b; e.c = c;
    expq.push_back(e);
  endtask

  task automatic ev_check(input int kind, input int a, input int b, input logic [31:0] c);
    ev_t e;
    n_total++;
    if (expq.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected event: kind=%0d a=%0d b=%0d c=%h", kind, a, b, c);
    end else begin
      e = expq.pop_front();
      if (e.kind != kind || e.a != a || e.b != b || e.c !== c) begin
        n_bad++;
        $display("FAIL event: got kind=%0d a=%0d b=%0d c=%h want kind=%0d a=%0d b=%0d c=%h",
                 kind, a, b, c, e.kind, e.a, e.b, e.c);
      end
    end
  endtask

  // Monitor: every DUT output event is matched against the front of the queue.
  always @(negedge clk) begin
    if (op_start) ev_check(0, int'(op_sel), 0, 32'h0);
    if (beat_rd)  ev_check(1, int'(op_sel), int'(beat_idx), 32'h0);
    if (done) begin
      ev_check(2, int'(status), int'(iter), rs_old);
      chk("busy_low_at_done", {63'h0, busy}, 64'h0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ev(input int which, input string nm);
    int t;
    bit hit;
    t = 0;
    hit = 1'b0;
    do begin
      @(negedge clk);
      t++;
      hit = (which == 0) ? op_start : done;
    end while (!hit && t < 300);
    if (!hit) begin
      n_total++;
      n_bad++;
      $display("FAIL timeout %s: no event in %0d cycles", nm, t);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"},     {63'h0, busy},     64'h0);
    chk({nm, "_done"},     {63'h0, done},     64'h0);
    chk({nm, "_op_start"}, {63'h0, op_start}, 64'h0);
    chk({nm, "_beat_rd"},  {63'h0, beat_rd},  64'h0);
    chk({nm, "_op_sel"},   {61'h0, op_sel},   64'h0);
    chk({nm, "_beat_idx"}, {32'h0, beat_idx}, 64'h0);
    chk({nm, "_rs_old"},   {32'h0, rs_old},   64'h0);
    chk({nm, "_rs_new"},   {32'h0, rs_new},   64'h0);
    chk({nm, "_iter"},     {48'h0, iter},     64'h0);
    chk({nm, "_status"},   {62'h0, status},   64'h0);
  endtask

  task automatic start_solve(input int t_len, input logic [31:0] t_tol, input int t_max);
    tot = t_len; tol = t_tol; max_iter = 16'(t_max);
    go = 1'b1;
    tick;
    go = 1'b0;
  endtask

  // Plays the unit for one stage: expects start and nb beats, then answers with res.
  // hold>0: beat_rdy is low on entry and must gate beats for hold cycles; go is pulsed meanwhile.
  task automatic run_stage(input int sel, input int nb, input logic [31:0] res, input int hold);
    int got;
    int t;
    push(0, sel, 0, 32'h0);
    for (int i = 0; i < nb; i++) push(1, sel, i, 32'h0);
    wait_ev(0, "op_start");
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("beat_held_off", {63'h0, beat_rd}, 64'h0);
        go = (i == 1);
      end
      go = 1'b0;
      tick;
      beat_rdy = 1'b1;
    end
    got = 0;
    t = 0;
    while (got < nb && t < 100) begin
      @(negedge clk);
      t++;
      if (beat_rd) got++;
    end
    if (got < nb) begin
      n_total++;
      n_bad++;
      $display("FAIL timeout beats sel=%0d: got %0d want %0d", sel, got, nb);
    end
    tick;
    op_done = 1'b1;
    op_result = res;
    tick;
    op_done = 1'b0;
  endtask

  logic [31:0] rrv [1:3];

  initial begin
    reset = 1'b1; go = 1'b0; abort = 1'b0; op_done = 1'b0; beat_rdy = 1'b1;
    tot = 0; tol = 0; op_result = 0; max_iter = 0;
    rrv[1] = 32'h3F800000; rrv[2] = 32'h3F000000; rrv[3] = 32'h3E800000;
    repeat (3) tick;
    reset = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    tick;

    // converge on the first RR: 2 beats per stream
    start_solve(16, TOL, 0);
    run_stage(0, 2, 32'h3F800000, 0);
    run_stage(1, 2, 32'h0, 0);
    run_stage(2, 0, 32'h3C000000, 0);
    run_stage(3, 2, 32'h0, 0);
    run_stage(4, 2, 32'h20000000, 0);
    push(2, 0, 0, 32'h3F800000);
    wait_ev(1, "done_t1");
    chk("t1_rs_new", {32'h0, rs_new}, {32'h0, 32'h20000000});
    tick;

    // total=20: 3 beats, beat_rdy low for 4 cycles, go while busy ignored
    beat_rdy = 1'b0;
    start_solve(20, TOL, 0);
    run_stage(0, 3, 32'h3F800000, 4);
    run_stage(1, 3, 32'h0, 0);
    run_stage(2, 0, 32'h3C000000, 0);
    run_stage(3, 3, 32'h0, 0);
    run_stage(4, 3, 32'h00000000, 0);
    push(2, 0, 0, 32'h3F800000);
    wait_ev(1, "done_t3");
    tick;

    // iteration limit 3: three full iterations, rs_old follows rs_new after each P
    start_solve(8, TOL, 3);
    run_stage(0, 1, 32'h40000000, 0);
    for (int k = 1; k <= 3; k++) begin
      run_stage(1, 1, 32'h0, 0);
      run_stage(2, 0, 32'h3C000000, 0);
      run_stage(3, 1, 32'h0, 0);
      run_stage(4, 1, rrv[k], 0);
      run_stage(5, 0, 32'h3F000000, 0);
      run_stage(6, 1, 32'h0, 0);
      if (k < 3) begin
        chk("limit_iter", {48'h0, iter}, 64'(k));
        chk("limit_rs_old", {32'h0, rs_old}, {32'h0, rrv[k]});
      end
    end
    push(2, 1, 3, rrv[3]);
    wait_ev(1, "done_limit");
    tick;

    // zero length: done exactly 2 cycles after go, no op_start
    push(2, 3, 0, 32'h0);
    tot = 0; tol = TOL; max_iter = 0;
    go = 1'b1;
    @(negedge clk);
    chk("zlen_c0_done", {63'h0, done}, 64'h0);
    tick;
    go = 1'b0;
    @(negedge clk);
    chk("zlen_c1_done", {63'h0, done}, 64'h0);
    chk("zlen_c1_busy", {63'h0, busy}, 64'h1);
    tick;
    @(negedge clk);
    chk("zlen_c2_done", {63'h0, done}, 64'h1);
    tick;

    // abort on AP beat 1, with a simultaneous op_done that must be ignored
    start_solve(24, TOL, 0);
    run_stage(0, 3, 32'h3F800000, 0);
    push(0, 1, 0, 32'h0);
    push(1, 1, 0, 32'h0);
    push(1, 1, 1, 32'h0);
    push(2, 2, 0, 32'h3F800000);
    wait_ev(0, "ap_start");
    tick;
    tick;
    abort = 1'b1;
    op_done = 1'b1;
    op_result = 32'h0;
    @(negedge clk);
    tick;
    op_done = 1'b0;
    @(negedge clk);
    chk("abort_done", {63'h0, done}, 64'h1);
    tick;
    @(negedge clk);
    chk("abort_idle_busy", {63'h0, busy}, 64'h0);
    chk("abort_idle_start", {63'h0, op_start}, 64'h0);
    abort = 1'b0;
    tick;

    // restart after abort: tiny RR0 result converges with no AP stage
    start_solve(8, TOL, 0);
    run_stage(0, 1, 32'h00000001, 0);
    push(2, 0, 0, 32'h00000001);
    wait_ev(1, "done_rr0");
    tick;

    // reset during XR: outputs clear, no done, then a full two-iteration solve
    start_solve(8, TOL, 0);
    run_stage(0, 1, 32'h3F800000, 0);
    run_stage(1, 1, 32'h0, 0);
    run_stage(2, 0, 32'h3C000000, 0);
    push(0, 3, 0, 32'h0);
    push(1, 3, 0, 32'h0);
    wait_ev(0, "xr_start");
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    @(negedge clk);
    chk_zero("midreset");
    tick;
    start_solve(16, TOL, 0);
    run_stage(0, 2, 32'h3F800000, 0);
    run_stage(1, 2, 32'h0, 0);
    run_stage(2, 0, 32'h3C000000, 0);
    run_stage(3, 2, 32'h0, 0);
    run_stage(4, 2, 32'h3F000000, 0);
    run_stage(5, 0, 32'h3E000000, 0);
    run_stage(6, 2, 32'h0, 0);
    run_stage(1, 2, 32'h0, 0);
    run_stage(2, 0, 32'h3C000000, 0);
    run_stage(3, 2, 32'h0, 0);
    run_stage(4, 2, 32'h00000000, 0);
    push(2, 0, 1, 32'h3F000000);
    wait_ev(1, "done_after_reset");
    repeat (4) tick;

    chk("queue_drained", 64'(expq.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
